// File: rtl/click_pkg.sv
// Shared types and helpers for the click classifier.
package click_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } click_state_t;

  // Width needed to hold a press count of 0..max.
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/click_window_timer.sv
// Gap timer between presses: counts 0..WINDOW_CYC-1 and holds at terminal count.
module click_window_timer #(
  parameter int WINDOW_CYC = 5,
  localparam int TMR_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam logic [TMR_W-1:0] TC = TMR_W'(WINDOW_CYC - 1);

  logic [TMR_W-1:0] timer_q;

  // Count up while not cleared, saturating at terminal count so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer_q <= '0;
    end else if (timer_q != TC) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  assign expire = (timer_q == TC);

endmodule

// File: rtl/click_classifier.sv
// Groups debounced press pulses into gestures and reports the press count.
// Optional build macro: CLICK_IRQ_EN adds a sticky irq output with irq_clr.
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | no gesture in progress
// ST_COLLECT | gesture open, waiting for next press or window timeout
// ST_EMIT    | one-cycle report of the finished gesture
module click_classifier
  import click_pkg::*;
#(
  parameter int CLK_HZ     = 125_000_000,
  parameter int WINDOW_MS  = 300,
  parameter int MAX_CLICKS = 3,
  localparam int WINDOW_CYC = (CLK_HZ / 1000) * WINDOW_MS,
  localparam int CNT_W      = cnt_width(MAX_CLICKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             press_pulse,
  output logic             click_valid,
  output logic [CNT_W-1:0] click_count,
  output logic             busy
`ifdef CLICK_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CLICKS);

  click_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             expire;
  logic             tmr_clear;

  // The window only runs while collecting; any press restarts it.
  assign tmr_clear = press_pulse || (state_q != ST_COLLECT);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  click_window_timer #(.WINDOW_CYC(WINDOW_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .expire (expire)
  );

  // Next-state and press-count decode; a press beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (press_pulse) begin
          state_d = ST_COLLECT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_COLLECT: begin
        if (press_pulse) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = ST_EMIT;
        end else if (expire) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (press_pulse) begin
          state_d = ST_COLLECT;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      click_valid <= 1'b0;
      click_count <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      click_valid <= (state_d == ST_EMIT);
      click_count <= (state_d == ST_EMIT) ? cnt_d : '0;
      busy        <= (state_d != ST_IDLE);
    end
  end

`ifdef CLICK_IRQ_EN
  // Sticky interrupt; a new strobe takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (click_valid) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
